// File: rtl/gf_xform_pkg.sv
// Shared types and constants for the GF(2) bit-matrix transform pipeline.
// Matrices are packed so that index r holds the mask for output bit r.
package gf_xform_pkg;

  typedef enum logic [1:0] {
    SEL_ID   = 2'd0,
    SEL_A2   = 2'd1,
    SEL_PROG = 2'd2,
    SEL_AFF  = 2'd3
  } sel_e;

  typedef logic [7:0][7:0] mat8_t;

  // Fixed composite-field isomorphic map, rows o7..o0
  localparam mat8_t A2_ROWS    = {8'hC0, 8'h28, 8'h60, 8'h94, 8'hF0, 8'h22, 8'hD0, 8'h51};
  localparam mat8_t IDENT_ROWS = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  localparam logic [3:0] CFG_ADDR_CONST = 4'd8;

endpackage

// File: rtl/gf_matmul8.sv
// Combinational 8x8 GF(2) matrix-vector product: out bit r is the parity of row r AND din.
module gf_matmul8
  import gf_xform_pkg::*;
(
  input  mat8_t      rows,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb begin
    dout = '0;
    for (int r = 0; r < 8; r++) begin
      dout[r] = ^(rows[r] & din);
    end
  end

endmodule

// File: rtl/gf_lin_xform_pipe.sv
// Multi-lane pipelined GF(2) linear/affine byte transform with valid/ready flow control
// and a runtime-programmable matrix plus affine constant.
module gf_lin_xform_pipe
  import gf_xform_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic               busy
);

  mat8_t      prog_rows;
  logic [7:0] const_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_rows <= IDENT_ROWS;
      const_q   <= '0;
    end else if (cfg_we) begin
      if (!cfg_addr[3]) begin
        prog_rows[cfg_addr[2:0]] <= cfg_wdata;
      end else if (cfg_addr == CFG_ADDR_CONST) begin
        const_q <= cfg_wdata;
      end
    end
  end

  sel_e       sel;
  mat8_t      rows_sel;
  logic [7:0] xor_mask;

  assign sel = sel_e'(in_sel);

  always_comb begin
    rows_sel = IDENT_ROWS;
    xor_mask = '0;
    case (sel)
      SEL_A2:   rows_sel = A2_ROWS;
      SEL_PROG: rows_sel = prog_rows;
      SEL_AFF: begin
        rows_sel = prog_rows;
        xor_mask = const_q;
      end
      default:  rows_sel = IDENT_ROWS;
    endcase
  end

  logic [8*LANES-1:0] xf_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] lane_out;

    gf_matmul8 u_matmul (
      .rows (rows_sel),
      .din  (in_data[8*k +: 8]),
      .dout (lane_out)
    );

    assign xf_data[8*k +: 8] = lane_out ^ xor_mask;
  end

  logic [STAGES-1:0]              v;
  logic [STAGES-1:0]              stage_rdy;
  logic [STAGES-1:0][8*LANES-1:0] pd;
  logic                           accept;

  // A stage can take a new beat if it or anything downstream has a hole, or the sink drains
  always_comb begin
    logic all_full;
    all_full  = 1'b1;
    stage_rdy = '0;
    for (int s = 0; s < STAGES; s++) begin
      all_full = 1'b1;
      for (int j = s; j < STAGES; j++) begin
        all_full = all_full & v[j];
      end
      stage_rdy[s] = out_ready | ~all_full;
    end
  end

  assign in_ready = stage_rdy[0] & ~flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= '0;
      pd <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (stage_rdy[0]) begin
        v[0] <= accept;
        if (accept) begin
          pd[0] <= xf_data;
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        if (stage_rdy[s]) begin
          v[s] <= v[s-1];
          if (v[s-1]) begin
            pd[s] <= pd[s-1];
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = pd[STAGES-1];
  assign busy      = |v;

endmodule

// File: tb/tb_gf_lin_xform_pipe.sv
// Randomized self-checking bench for gf_lin_xform_pipe against a parity-based matrix model
// and a timestamped scoreboard of beats in flight.
module tb_gf_lin_xform_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 2;

  localparam logic [7:0] A2_TB [8] = '{8'h51, 8'hD0, 8'h22, 8'hF0, 8'h94, 8'h60, 8'h28, 8'hC0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = 2'd0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        busy;

  gf_lin_xform_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] d;
    int          acc;
  } beat_t;

  beat_t       sb[$];
  logic [7:0]  prog_m [8];
  logic [7:0]  const_m;
  logic [31:0] last_out;
  int          last_lat;
  int          n_out;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [31:0] model_xf(input logic [1:0] sel, input logic [31:0] d);
    logic [31:0] res;
    logic [7:0]  b, row, o;
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      b = d[8*k +: 8];
      o = '0;
      for (int r = 0; r < 8; r++) begin
        case (sel)
          2'd0:    row = 8'(1 << r);
          2'd1:    row = A2_TB[r];
          default: row = prog_m[r];
        endcase
        o[r] = ($countones(row & b) % 2) == 1;
      end
      if (sel == 2'd3) o = o ^ const_m;
      res[8*k +: 8] = o;
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) prog_m[r] = 8'(1 << r);
    const_m = '0;
    sb.delete();
  endtask

  // One clock cycle: drive at negedge, check model expectations, update model, advance
  task automatic applyStimulus(input bit v, input logic [1:0] sel, input logic [31:0] d,
                               input bit ordy, input bit we, input logic [3:0] a,
                               input logic [7:0] wd, input bit fl, output bit acc);
    bit    exp_ov, exp_rdy;
    beat_t h, nb;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = wd;
    flush     = fl;
    #1;
    exp_ov  = (sb.size() > 0) && (cycle >= sb[0].acc + STAGES);
    exp_rdy = !fl && (ordy || sb.size() < STAGES);
    checkOutput("out_valid", 32'(out_valid), 32'(exp_ov));
    checkOutput("busy", 32'(busy), 32'(sb.size() != 0));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_ov && !ordy) checkOutput("stall_data", out_data, sb[0].d);
    if (exp_ov && ordy) begin
      h = sb.pop_front();
      checkOutput("out_data", out_data, h.d);
      last_out = out_data;
      last_lat = cycle - h.acc;
      n_out++;
    end
    acc = v && exp_rdy;
    if (acc) begin
      nb.d   = model_xf(sel, d);
      nb.acc = cycle;
      sb.push_back(nb);
    end
    if (we) begin
      if (a < 4'd8) prog_m[a[2:0]] = wd;
      else if (a == 4'd8) const_m = wd;
    end
    if (fl) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    applyStimulus(1'b0, 2'd0, '0, ordy, 1'b0, 4'd0, 8'd0, 1'b0, acc);
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] d);
    bit acc;
    applyStimulus(1'b1, sel, d, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, acc);
  endtask

  task automatic cfg(input logic [3:0] a, input logic [7:0] wd);
    bit acc;
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b1, a, wd, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
    if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    int          sent, base;
    logic [31:0] stream [10];

    n_out = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] fixed A2 map");
    send(2'd1, 32'hFF800100);
    drain();
    checkOutput("t1_data", last_out, 32'h139A0100);
    checkOutput("t1_latency", 32'(last_lat), 32'(STAGES));

    $display("[TB] identity via sel 0 and reset PROG");
    send(2'd0, 32'h5A5A5A5A);
    drain();
    checkOutput("t2_sel0", last_out, 32'h5A5A5A5A);
    send(2'd2, 32'h5A5A5A5A);
    drain();
    checkOutput("t2_sel2", last_out, 32'h5A5A5A5A);

    $display("[TB] programmable rows and write/accept ordering");
    for (int r = 0; r < 8; r++) cfg(4'(r), 8'(1 << (7 - r)));
    send(2'd2, 32'h01010101);
    drain();
    checkOutput("t3_reversed", last_out, 32'h80808080);
    for (int r = 0; r < 8; r++) cfg(4'(r), 8'(1 << r));
    applyStimulus(1'b1, 2'd2, 32'h01010101, 1'b1, 1'b1, 4'd7, 8'h01, 1'b0, acc);
    drain();
    checkOutput("t3_old_row", last_out, 32'h01010101);
    send(2'd2, 32'h01010101);
    drain();
    checkOutput("t3_new_row", last_out, 32'h81818181);
    cfg(4'd7, 8'h80);

    $display("[TB] affine constant");
    cfg(4'd8, 8'h63);
    send(2'd3, 32'h00000000);
    drain();
    checkOutput("t4_zero", last_out, 32'h63636363);
    send(2'd3, 32'h63636363);
    drain();
    checkOutput("t4_cancel", last_out, 32'h00000000);

    $display("[TB] backpressure stream");
    for (int i = 0; i < 10; i++) stream[i] = $urandom;
    sent = 0;
    base = n_out;
    for (int c = 0; c < 40 && (sent < 10 || sb.size() > 0); c++) begin
      applyStimulus(sent < 10, 2'(c % 4), stream[sent % 10], !(c >= 3 && c < 8),
                    1'b0, 4'd0, 8'd0, 1'b0, acc);
      if (acc) sent++;
    end
    checkOutput("t5_count", 32'(n_out - base), 32'd10);

    $display("[TB] async reset mid-stream");
    cfg(4'd0, 8'hFF);
    send(2'd1, $urandom);
    send(2'd2, $urandom);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd2, 32'hA5C30F81);
    drain();
    checkOutput("t6_prog_ident", last_out, 32'hA5C30F81);

    $display("[TB] flush and ignored cfg addresses");
    cfg(4'd8, 8'h3C);
    send(2'd0, $urandom);
    send(2'd1, $urandom);
    applyStimulus(1'b1, 2'd0, 32'h12345678, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, acc);
    idle(1'b1);
    for (int a = 9; a < 16; a++) cfg(4'(a), 8'hFF);
    send(2'd3, 32'h00000000);
    drain();
    checkOutput("t6_const_kept", last_out, 32'h3C3C3C3C);
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b1, 4'd8, 8'h11, 1'b1, acc);
    send(2'd3, 32'h00000000);
    drain();
    checkOutput("t6_flush_cfg", last_out, 32'h11111111);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 39) == 0, acc);
    end
    drain();
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
